merlin_prefetch_ctrl: RTL and testbench

//  Instruction prefetch controller, directly upstream of the instruction buffer FIFO (merlin_fifo,

---
 rtl/merlin_prefetch_ctrl_pkg.sv | 22 ++
 rtl/merlin_prefetch_ctrl.sv | 113 +++++++++++
 tb/tb_merlin_prefetch_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/merlin_prefetch_ctrl_pkg.sv
// Shared types and helpers for the instruction prefetch controller:
// FSM state encoding, FIFO entry layout and PC arithmetic.
package merlin_prefetch_ctrl_pkg;

  typedef enum logic {
    PFU_FETCH = 1'b0,
    PFU_FAULT = 1'b1
  } pfu_state_e;

  localparam int PFU_FAULT_BIT = 64;
  localparam int PFU_WIDTH     = 65;

  // Sequential fetch steps one 32-bit word; wraps naturally at 2**32.
  function automatic logic [31:0] pfu_pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] pfu_word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/merlin_prefetch_ctrl.sv
// Sequential instruction prefetcher feeding the instruction buffer FIFO.
// Credit-counts FIFO space and discards stale responses after a jump or fault.
module merlin_prefetch_ctrl
  import merlin_prefetch_ctrl_pkg::*;
#(
  parameter int          C_FIFO_DEPTH_X = 2,
  parameter logic [31:0] C_RESET_VECTOR = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 jump_i,
  input  logic [31:0]          jump_addr_i,
  output logic                 ireqvalid_o,
  input  logic                 ireqready_i,
  output logic [31:0]          ireqaddr_o,
  input  logic                 irspvalid_i,
  input  logic                 irsperr_i,
  input  logic [31:0]          irspdata_i,
  output logic                 fifo_flush_o,
  output logic                 fifo_wr_o,
  output logic [PFU_WIDTH-1:0] fifo_din_o,
  input  logic                 fifo_rd_i
);

  localparam int              CW      = C_FIFO_DEPTH_X + 1;
  localparam int              DEPTH_I = 1 << C_FIFO_DEPTH_X;
  localparam logic [CW-1:0]   DEPTH   = CW'(DEPTH_I);

  pfu_state_e    state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] live_q, live_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW:0]   credit_sum;
  logic          credit_ok;
  logic          req_xfer;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          rsp_fault;
  logic          fifo_full;
  logic          rd_eff;
  logic [CW-1:0] live_after;
  logic [31:0]   jump_target;

  always_comb begin
    credit_sum   = {1'b0, occ_q} + {1'b0, live_q};
    credit_ok    = credit_sum < {1'b0, DEPTH};
    ireqvalid_o  = ~reset_i & (state_q == PFU_FETCH) & ~jump_i & credit_ok;
    ireqaddr_o   = req_pc_q;
    req_xfer     = ireqvalid_o & ireqready_i;

    // A response either retires a drop credit or is a kept instruction.
    rsp_keep     = irspvalid_i & ~jump_i & (drop_q == '0);
    rsp_drop     = irspvalid_i & ~jump_i & (drop_q != '0);
    rsp_fault    = rsp_keep & irsperr_i & (state_q == PFU_FETCH);

    fifo_wr_o    = ~reset_i & rsp_keep;
    fifo_flush_o = ~reset_i & jump_i;
    fifo_din_o   = {irsperr_i, rsp_pc_q, irspdata_i};
    fifo_full    = (occ_q == DEPTH);
    rd_eff       = fifo_rd_i & (occ_q != '0);
    jump_target  = pfu_word_align(jump_addr_i);
  end

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_xfer ? pfu_pc_inc(req_pc_q) : req_pc_q;
    rsp_pc_d   = rsp_keep ? pfu_pc_inc(rsp_pc_q) : rsp_pc_q;
    live_after = live_q + CW'(req_xfer) - CW'(rsp_keep);
    live_d     = live_after;
    drop_d     = drop_q - CW'(rsp_drop);
    occ_d      = occ_q + CW'(fifo_wr_o) - CW'(rd_eff);

    if (jump_i) begin
      // Every outstanding request becomes stale; a response this cycle retires one.
      state_d  = PFU_FETCH;
      drop_d   = drop_q + live_q - CW'(irspvalid_i);
      live_d   = '0;
      occ_d    = '0;
      req_pc_d = jump_target;
      rsp_pc_d = jump_target;
    end else if (rsp_fault) begin
      // Includes a request accepted in this same cycle.
      state_d  = PFU_FAULT;
      drop_d   = drop_q + live_after;
      live_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= PFU_FETCH;
      req_pc_q <= C_RESET_VECTOR;
      rsp_pc_q <= C_RESET_VECTOR;
      occ_q    <= '0;
      live_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      occ_q    <= occ_d;
      live_q   <= live_d;
      drop_q   <= drop_d;
    end
  end

  a_no_write_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
    !(fifo_wr_o && fifo_full));

endmodule

// File: tb/tb_merlin_prefetch_ctrl.sv
// Randomised bench for merlin_prefetch_ctrl: in-order bus model with variable
// latency, and a queue-based reference model of requests and FIFO contents.
module tb_merlin_prefetch_ctrl;

  localparam int DX    = 2;
  localparam int DEPTH = 1 << DX;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        jump_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        ireqvalid_o;
  logic        ireqready_i = 1'b0;
  logic [31:0] ireqaddr_o;
  logic        irspvalid_i = 1'b0;
  logic        irsperr_i = 1'b0;
  logic [31:0] irspdata_i = '0;
  logic        fifo_flush_o;
  logic        fifo_wr_o;
  logic [64:0] fifo_din_o;
  logic        fifo_rd_i = 1'b0;

  always #5 clk_i = ~clk_i;

  merlin_prefetch_ctrl #(
    .C_FIFO_DEPTH_X(DX),
    .C_RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .jump_i      (jump_i),
    .jump_addr_i (jump_addr_i),
    .ireqvalid_o (ireqvalid_o),
    .ireqready_i (ireqready_i),
    .ireqaddr_o  (ireqaddr_o),
    .irspvalid_i (irspvalid_i),
    .irsperr_i   (irsperr_i),
    .irspdata_i  (irspdata_i),
    .fifo_flush_o(fifo_flush_o),
    .fifo_wr_o   (fifo_wr_o),
    .fifo_din_o  (fifo_din_o),
    .fifo_rd_i   (fifo_rd_i)
  );

  typedef struct { logic [31:0] addr; bit keep; } mreq_t;
  typedef struct { logic [31:0] addr; int due; } breq_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  mreq_t       m_out[$];
  logic [64:0] m_fifo[$];
  bit          m_fault;
  logic [31:0] m_pc;
  breq_t       bus_q[$];
  logic [31:0] req_log[$];
  logic [64:0] wr_log[$];

  int          k_ready = 100, k_rsp = 100, k_rd = 0, k_jump = 0, k_err = 0;
  int          lat_min = 1, lat_max = 1;
  logic [31:0] err_addr = 32'h1;
  bit          jr_hit;

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]};
  endfunction

  function automatic int keep_cnt();
    int n = 0;
    foreach (m_out[i]) if (m_out[i].keep) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out.delete();
    m_fifo.delete();
    bus_q.delete();
    m_fault = 1'b0;
    m_pc    = 32'h0;
  endtask

  // jmode: 0 random jumps, 1 forced jump, 2 jump only if a response arrives.
  task automatic step(input int jmode, input logic [31:0] jaddr, input bit do_reset);
    bit          rv, re, exp_v, exp_wr;
    logic [31:0] rd;
    logic [64:0] exp_din;
    mreq_t       h;
    @(negedge clk_i);
    reset_i = do_reset;
    rv = 1'b0;
    re = 1'b0;
    rd = $urandom;
    if (!do_reset && bus_q.size() > 0 && bus_q[0].due <= cyc && $urandom_range(99) < k_rsp) begin
      rv = 1'b1;
      re = (bus_q[0].addr == err_addr) || ($urandom_range(99) < k_err);
      rd = rdata(bus_q[0].addr);
    end
    irspvalid_i = rv;
    irsperr_i   = re;
    irspdata_i  = rd;
    if (jmode == 1) jump_i = 1'b1;
    else if (jmode == 2) jump_i = rv;
    else jump_i = !do_reset && ($urandom_range(999) < k_jump);
    jump_addr_i = (jmode != 0) ? jaddr : $urandom;
    if (jmode == 2 && rv) jr_hit = 1'b1;
    ireqready_i = $urandom_range(99) < k_ready;
    fifo_rd_i   = (m_fifo.size() > 0) && ($urandom_range(99) < k_rd);
    #1;
    if (do_reset) begin
      chk("rst_ireqvalid", 65'(ireqvalid_o), 65'd0);
      chk("rst_fifo_wr", 65'(fifo_wr_o), 65'd0);
      chk("rst_flush", 65'(fifo_flush_o), 65'd0);
      model_reset();
    end else begin
      exp_v = !m_fault && !jump_i && (m_fifo.size() + keep_cnt() < DEPTH);
      chk("ireqvalid", 65'(ireqvalid_o), 65'(exp_v));
      if (exp_v) chk("ireqaddr", 65'(ireqaddr_o), 65'(m_pc));
      chk("fifo_flush", 65'(fifo_flush_o), 65'(jump_i));
      exp_wr  = 1'b0;
      exp_din = '0;
      if (rv) begin
        if (m_out.size() == 0) begin
          chk("rsp_without_request", 65'd1, 65'd0);
        end else begin
          h = m_out.pop_front();
          exp_wr  = !jump_i && h.keep;
          exp_din = {irsperr_i, h.addr, irspdata_i};
        end
        void'(bus_q.pop_front());
      end
      chk("fifo_wr", 65'(fifo_wr_o), 65'(exp_wr));
      if (exp_wr) chk("fifo_din", fifo_din_o, exp_din);

      if (ireqvalid_o && ireqready_i) begin
        req_log.push_back(ireqaddr_o);
        bus_q.push_back('{ireqaddr_o, cyc + int'($urandom_range(lat_max, lat_min))});
      end
      if (fifo_wr_o) begin
        wr_log.push_back(fifo_din_o);
        $display("cycle %0d fifo write pc=%h fault=%b instr=%h",
                 cyc, fifo_din_o[63:32], fifo_din_o[64], fifo_din_o[31:0]);
      end

      if (jump_i) m_fifo.delete();
      else begin
        if (fifo_rd_i && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (exp_wr) m_fifo.push_back(exp_din);
      end
      if (exp_v && ireqready_i) begin
        m_out.push_back('{m_pc, 1'b1});
        m_pc = m_pc + 32'd4;
      end
      if ((exp_wr && irsperr_i) || jump_i) foreach (m_out[i]) m_out[i].keep = 1'b0;
      if (exp_wr && irsperr_i) m_fault = 1'b1;
      if (jump_i) begin
        m_fault = 1'b0;
        m_pc    = {jump_addr_i[31:2], 2'b00};
      end
    end
    cyc++;
  endtask

  initial begin
    int n0, w0, n1;
    logic [31:0] a0;
    model_reset();
    repeat (3) step(0, 32'h0, 1'b1);

    // Sequential fill with no pops: exactly DEPTH requests then stall.
    repeat (8) step(0, 32'h0, 1'b0);
    chk("t1_nreq", 65'(req_log.size()), 65'd4);
    chk("t1_nwr", 65'(wr_log.size()), 65'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_req_addr", 65'(req_log.size() > i ? req_log[i] : 32'hDEAD_BEEF), 65'(32'(i * 4)));
      chk("t1_wr_pc", 65'(wr_log.size() > i ? wr_log[i][63:32] : 32'hDEAD_BEEF), 65'(32'(i * 4)));
    end
    chk("t1_idle_valid", 65'(ireqvalid_o), 65'd0);

    // A single pop frees one credit.
    k_rd = 100;
    step(0, 32'h0, 1'b0);
    k_rd = 0;
    repeat (6) step(0, 32'h0, 1'b0);
    chk("t2_nreq", 65'(req_log.size()), 65'd5);
    chk("t2_req_addr", 65'(req_log.size() > 4 ? req_log[4] : 32'hDEAD_BEEF), 65'(32'h10));
    chk("t2_wr_pc", 65'(wr_log.size() > 4 ? wr_log[4][63:32] : 32'hDEAD_BEEF), 65'(32'h10));

    // Jump with three requests in flight.
    k_rd = 100; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && keep_cnt() < 3; i++) step(0, 32'h0, 1'b0);
    chk("t3_inflight", 65'(keep_cnt()), 65'd3);
    n0 = req_log.size();
    w0 = wr_log.size();
    step(1, 32'h2003, 1'b0);
    repeat (10) step(0, 32'h0, 1'b0);
    chk("t3_req_addr", 65'(req_log.size() > n0 ? req_log[n0] : 32'hDEAD_BEEF), 65'(32'h2000));
    chk("t3_wr_pc", 65'(wr_log.size() > w0 ? wr_log[w0][63:32] : 32'hDEAD_BEEF), 65'(32'h2000));

    // Bus error on the second response stops fetching until a jump.
    lat_min = 1; lat_max = 1;
    err_addr = 32'h3004;
    step(1, 32'h3000, 1'b0);
    n0 = req_log.size();
    w0 = wr_log.size();
    repeat (8) step(0, 32'h0, 1'b0);
    chk("t4_nreq", 65'(req_log.size() - n0), 65'd3);
    chk("t4_nwr", 65'(wr_log.size() - w0), 65'd2);
    chk("t4_wr0", wr_log.size() > w0 ? wr_log[w0] : '1, {1'b0, 32'h3000, rdata(32'h3000)});
    chk("t4_wr1", wr_log.size() > w0 + 1 ? wr_log[w0 + 1] : '1, {1'b1, 32'h3004, rdata(32'h3004)});
    chk("t4_fault_idle", 65'(ireqvalid_o), 65'd0);
    err_addr = 32'h1;
    step(1, 32'h100, 1'b0);
    n1 = req_log.size();
    repeat (3) step(0, 32'h0, 1'b0);
    chk("t4_resume_addr", 65'(req_log.size() > n1 ? req_log[n1] : 32'hDEAD_BEEF), 65'(32'h100));

    // Stall: address held, jump during stall retargets.
    k_ready = 0;
    step(0, 32'h0, 1'b0);
    a0 = ireqaddr_o;
    repeat (4) step(0, 32'h0, 1'b0);
    chk("t5_addr_stable", 65'(ireqaddr_o), 65'(a0));
    chk("t5_valid_held", 65'(ireqvalid_o), 65'd1);
    step(1, 32'h4000, 1'b0);
    k_ready = 100;
    n0 = req_log.size();
    repeat (2) step(0, 32'h0, 1'b0);
    chk("t5_target_addr", 65'(req_log.size() > n0 ? req_log[n0] : 32'hDEAD_BEEF), 65'(32'h4000));

    // Address wrap, then a jump that coincides with a response.
    step(1, 32'hFFFF_FFFC, 1'b0);
    n0 = req_log.size();
    repeat (3) step(0, 32'h0, 1'b0);
    chk("t6_wrap_hi", 65'(req_log.size() > n0 ? req_log[n0] : 32'hDEAD_BEEF), 65'(32'hFFFF_FFFC));
    chk("t6_wrap_lo", 65'(req_log.size() > n0 + 1 ? req_log[n0 + 1] : 32'hDEAD_BEEF), 65'(32'h0));
    jr_hit = 1'b0;
    for (int i = 0; i < 10 && !jr_hit; i++) step(2, 32'h500, 1'b0);
    chk("t6_jump_rsp_hit", 65'(jr_hit), 65'd1);
    chk("t6_wr_on_jump", 65'(fifo_wr_o), 65'd0);

    // Randomised traffic with jumps, errors and a mid-run reset.
    k_ready = 70; k_rsp = 60; k_rd = 50; k_jump = 30; k_err = 3;
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700 || i == 701) step(0, 32'h0, 1'b1);
      else step(0, 32'h0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
